// File: rtl/alu_mc_if.sv
// Operand/result channel of the multicycle ALU: one op in, one result out.
// Each direction is a valid/ready pair; a transfer occurs on the rising edge where both are 1, and the source holds its data until then.
interface alu_mc_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [4:0]      alu_op;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_res;
   logic            busy;
   logic [1:0]      dbgState;

   modport master (
      output in_valid, alu_a, alu_b, alu_op, out_ready,
      input  in_ready, out_valid, alu_res, busy, dbgState
   );

   modport slave (
      input  in_valid, alu_a, alu_b, alu_op, out_ready,
      output in_ready, out_valid, alu_res, busy, dbgState
   );
endinterface

// File: rtl/alu_mc.sv
// Multicycle ALU: base integer ops in one cycle, RV32M mul/div as XLEN-iteration
// shift-add / restoring units on operand magnitudes with a final sign fixup.
module alu_mc #(
   parameter  int XLEN = 32,
   localparam int SHW  = $clog2(XLEN)
) (
   input logic clk,
   input logic rst_n,
   alu_mc_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} stateT;

   localparam logic [4:0] OP_MUL    = 5'b10000;
   localparam logic [4:0] OP_MULH   = 5'b10001;
   localparam logic [4:0] OP_MULHSU = 5'b10010;
   localparam logic [4:0] OP_DIV    = 5'b10100;
   localparam logic [4:0] OP_REM    = 5'b10110;

   stateT             state, stateNext;
   logic [4:0]        opR;
   logic              negR, bZeroR;
   logic [XLEN-1:0]   mcandR, resR;
   logic [2*XLEN-1:0] acc, accStep, prodFix;
   logic [SHW-1:0]    cnt;

   logic            accept, isMop, signA, signB, negInit, lastIter;
   logic [XLEN-1:0] magA, magB, baseRes, fixRes, quo, rem;
   logic [SHW-1:0]  shamt;
   logic [XLEN:0]   mulSum, shiftRem, trial;
   logic [2*XLEN:0] mulWide;

   assign accept   = bus.in_valid && (state == IDLE);
   assign isMop    = (bus.alu_op[4:3] == 2'b10);
   assign lastIter = (cnt == SHW'(XLEN - 1));
   assign shamt    = bus.alu_b[SHW-1:0];

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (accept) stateNext = isMop ? BUSY : DONE;
         BUSY: if (lastIter) stateNext = DONE;
         DONE: if (bus.out_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      baseRes = '0;
      case (bus.alu_op)
         5'b00000: baseRes = bus.alu_a + bus.alu_b;
         5'b01000: baseRes = bus.alu_a - bus.alu_b;
         5'b00100: baseRes = bus.alu_a ^ bus.alu_b;
         5'b00110: baseRes = bus.alu_a | bus.alu_b;
         5'b00111: baseRes = bus.alu_a & bus.alu_b;
         5'b00001: baseRes = bus.alu_a << shamt;
         5'b00101: baseRes = bus.alu_a >> shamt;
         5'b01101: baseRes = $unsigned($signed(bus.alu_a) >>> shamt);
         5'b00010: baseRes = {{(XLEN-1){1'b0}}, ($signed(bus.alu_a) < $signed(bus.alu_b))};
         5'b00011: baseRes = {{(XLEN-1){1'b0}}, (bus.alu_a < bus.alu_b)};
         5'b11111: baseRes = bus.alu_b;
         default:  baseRes = '0;
      endcase
   end

   // MUL needs no sign handling: the low half is identical for signed and unsigned.
   always_comb begin
      signA   = bus.alu_a[XLEN-1] && (bus.alu_op == OP_MULH || bus.alu_op == OP_MULHSU ||
                                      bus.alu_op == OP_DIV  || bus.alu_op == OP_REM);
      signB   = bus.alu_b[XLEN-1] && (bus.alu_op == OP_MULH || bus.alu_op == OP_DIV ||
                                      bus.alu_op == OP_REM);
      magA    = signA ? (~bus.alu_a + 1'b1) : bus.alu_a;
      magB    = signB ? (~bus.alu_b + 1'b1) : bus.alu_b;
      negInit = (bus.alu_op == OP_REM) ? signA : (signA ^ signB);
   end

   // Multiply keeps the multiplier in acc low half; divide keeps the dividend/quotient there.
   always_comb begin
      mulSum   = acc[0] ? ({1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcandR})
                        : {1'b0, acc[2*XLEN-1:XLEN]};
      mulWide  = {mulSum, acc[XLEN-1:0]};
      shiftRem = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      trial    = shiftRem - {1'b0, mcandR};
      accStep  = '0;
      if (!opR[2]) accStep = mulWide[2*XLEN:1];
      else if (!trial[XLEN]) accStep = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else accStep = {shiftRem[XLEN-1:0], acc[XLEN-2:0], 1'b0};
   end

   always_comb begin
      prodFix = negR ? (~accStep + 1'b1) : accStep;
      quo     = accStep[XLEN-1:0];
      rem     = accStep[2*XLEN-1:XLEN];
      fixRes  = '0;
      case (opR[2:0])
         3'b000:         fixRes = accStep[XLEN-1:0];
         3'b001, 3'b010: fixRes = prodFix[2*XLEN-1:XLEN];
         3'b011:         fixRes = accStep[2*XLEN-1:XLEN];
         3'b100:         fixRes = bZeroR ? '1 : (negR ? (~quo + 1'b1) : quo);
         3'b101:         fixRes = bZeroR ? '1 : quo;
         3'b110:         fixRes = negR ? (~rem + 1'b1) : rem;
         3'b111:         fixRes = rem;
         default:        fixRes = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         opR    <= '0;
         negR   <= 1'b0;
         bZeroR <= 1'b0;
         mcandR <= '0;
         acc    <= '0;
         cnt    <= '0;
         resR   <= '0;
      end else begin
         state <= stateNext;
         if (accept) begin
            opR <= bus.alu_op;
            if (isMop) begin
               negR   <= negInit;
               bZeroR <= (bus.alu_b == '0);
               mcandR <= bus.alu_op[2] ? magB : magA;
               acc    <= {{XLEN{1'b0}}, (bus.alu_op[2] ? magA : magB)};
               cnt    <= '0;
            end else begin
               resR <= baseRes;
            end
         end else if (state == BUSY) begin
            acc <= accStep;
            cnt <= cnt + 1'b1;
            if (lastIter) resR <= fixRes;
         end
      end
   end

   assign bus.in_ready  = rst_n && (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state == BUSY);
   assign bus.alu_res   = resR;
   assign bus.dbgState  = state;
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: hand-computed vectors, latency and handshake checks.
module tb_alu_mc;
   logic clk;
   logic rst_n;
   int   errCnt = 0;
   int   chkCnt = 0;
   logic [31:0] exp_q[$];

   alu_mc_if #(.XLEN(32)) bus ();

   alu_mc #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      chkCnt++;
      if (obs !== expv) begin
         errCnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   // Issues one op, measures acceptance-to-out_valid latency and busy cycles, checks the result.
   task automatic runOp(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expRes, input int expLat);
      int lat;
      int busyCnt;
      exp_q.push_back(expRes);
      @(negedge clk);
      checkVal({tag, "_inrdy"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.alu_a    = a;
      bus.alu_b    = b;
      bus.alu_op   = op;
      @(posedge clk);
      lat     = 1;
      busyCnt = 0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      while (!bus.out_valid && lat < 200) begin
         if (bus.busy) busyCnt++;
         @(negedge clk);
         lat++;
      end
      checkVal({tag, "_lat"}, 32'(lat), 32'(expLat));
      checkVal({tag, "_busy"}, 32'(busyCnt), 32'(expLat - 1));
      checkVal({tag, "_res"}, bus.alu_res, exp_q.pop_front());
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checkVal({tag, "_ovdrop"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] held;
      bus.in_valid  = 1'b0;
      bus.alu_a     = '0;
      bus.alu_b     = '0;
      bus.alu_op    = '0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkVal("rst_inrdy", 32'(bus.in_ready), 32'd0);
      checkVal("rst_ovalid", 32'(bus.out_valid), 32'd0);
      checkVal("rst_busy", 32'(bus.busy), 32'd0);
      checkVal("rst_res", bus.alu_res, 32'd0);
      rst_n = 1'b1;
      #1;
      checkVal("rel_inrdy", 32'(bus.in_ready), 32'd1);

      runOp("add",    5'b00000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
      runOp("sub",    5'b01000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1);
      runOp("sra",    5'b01101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1);
      runOp("sll",    5'b00001, 32'h8000_0000, 32'h0000_0024, 32'h0000_0000, 1);
      runOp("srl",    5'b00101, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1);
      runOp("slt",    5'b00010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
      runOp("sltu",   5'b00011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
      runOp("xor",    5'b00100, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFF00_12CB, 1);
      runOp("or",     5'b00110, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFFF0_12FF, 1);
      runOp("and",    5'b00111, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034, 1);
      runOp("passb",  5'b11111, 32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);
      runOp("undef",  5'b01111, 32'h1234_5678, 32'hCAFE_F00D, 32'h0000_0000, 1);

      runOp("mulh",   5'b10001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33);
      runOp("mul",    5'b10000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 33);
      runOp("mulhu",  5'b10011, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 33);
      runOp("mulhsu", 5'b10010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      runOp("div",    5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
      runOp("rem",    5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
      runOp("divu",   5'b10101, 32'd100,       32'd7,         32'd14,        33);
      runOp("remu",   5'b10111, 32'd100,       32'd7,         32'd2,         33);
      runOp("divu0",  5'b10101, 32'd7,         32'd0,         32'hFFFF_FFFF, 33);
      runOp("remu0",  5'b10111, 32'd7,         32'd0,         32'd7,         33);
      runOp("div0",   5'b10100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 33);
      runOp("rem0",   5'b10110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 33);
      runOp("divovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
      runOp("removf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);

      // Backpressure: result held in DONE while a competing op is offered.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.alu_a    = 32'd10;
      bus.alu_b    = 32'd20;
      bus.alu_op   = 5'b00000;
      @(posedge clk);
      @(negedge clk);
      bus.alu_a = 32'd99;
      bus.alu_b = 32'd1;
      bus.alu_op = 5'b01000;
      checkVal("bp_ovalid", 32'(bus.out_valid), 32'd1);
      held = bus.alu_res;
      checkVal("bp_first", held, 32'd30);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkVal($sformatf("bp_hold%0d", i), bus.alu_res, 32'd30);
         checkVal($sformatf("bp_inrdy%0d", i), 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checkVal("bp_idle_ovalid", 32'(bus.out_valid), 32'd0);
      checkVal("bp_idle_inrdy", 32'(bus.in_ready), 32'd1);
      checkVal("bp_idle_state", 32'(bus.dbgState), 32'd0);
      runOp("bp_next", 5'b00000, 32'd4, 32'd5, 32'd9, 1);

      // Reset in the middle of a divide aborts it.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.alu_a    = 32'd1000;
      bus.alu_b    = 32'd3;
      bus.alu_op   = 5'b10101;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (9) @(negedge clk);
      checkVal("mid_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkVal("abort_ovalid", 32'(bus.out_valid), 32'd0);
      checkVal("abort_busy", 32'(bus.busy), 32'd0);
      checkVal("abort_inrdy", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      runOp("post_add", 5'b00000, 32'd2, 32'd3, 32'd5, 1);

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multicycle ALU for the multicycle/pipelined core generation.
- Keeps the single-cycle ALU op encoding for base integer ops and adds RV32M multiply/divide as iterative XLEN-cycle units.
- Operands and results cross valid/ready handshakes, so the control FSM can stall on long ops.
- Sits between the register-read/operand-mux stage and the writeback mux.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, >= 8.
- SHW, $clog2(XLEN), shift-amount width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  unit accepts a new op.
- alu_a  in  XLEN  operand A.
- alu_b  in  XLEN  operand B.
- alu_op  in  5  operation code (see Behaviour).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- alu_res  out  XLEN  result, stable while out_valid=1.
- busy  out  1  iterative mul/div in progress.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=0 while reset asserted then 1, out_valid=0, busy=0, alu_res=0, internal accumulators cleared. Reset mid-operation aborts the op; no result is produced.
- FSM states IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, latch alu_a, alu_b, alu_op.
    - Base op -> DONE next cycle (latency 1).
    - M op -> BUSY.
  - BUSY: in_ready=0, busy=1. Runs one iteration per cycle for exactly XLEN cycles, then post-sign-fixup in the same edge -> DONE.
    - Acceptance-to-out_valid latency for M ops = XLEN+1 cycles.
  - DONE: out_valid=1, in_ready=0, alu_res held. On out_ready=1 -> IDLE; in_ready rises the next cycle. No back-to-back overlap.
- Base ops (all arithmetic modulo 2^XLEN):
  - 00000 ADD; 01000 SUB.
  - 00100 XOR; 00110 OR; 00111 AND.
  - 00001 SLL; 00101 SRL; 01101 SRA. Shift amount = alu_b[SHW-1:0] only; upper bits ignored.
  - 00010 SLT (signed); 00011 SLTU. Result is 1 or 0, zero-extended.
  - 11111 PASSB: result = alu_b.
- M ops, iterative:
  - 10000 MUL: low XLEN bits.
  - 10001 MULH: signed x signed, high half.
  - 10010 MULHSU: signed A x unsigned B, high half.
  - 10011 MULHU: unsigned, high half.
  - 10100 DIV (signed); 10101 DIVU.
  - 10110 REM (signed, sign follows dividend); 10111 REMU.
- Multiplier: shift-add on magnitudes with a 2*XLEN accumulator; negate the product at the end if signs differ.
- Divider: restoring, on magnitudes; quotient/remainder sign fixup at the end.
- Divide-by-zero: DIV/DIVU result all ones; REM/REMU result = alu_a. Still takes the full XLEN+1 cycles.
- Signed overflow (alu_a = -2^(XLEN-1), alu_b = -1): DIV result = alu_a; REM result = 0.
- Undefined opcode: treated as base op, result 0, latency 1.
- in_valid while in_ready=0 is ignored; the source must hold its data.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset then ADD: a=0x7FFFFFFF, b=1, op=00000 -> out_valid 1 cycle after accept, alu_res=0x80000000. SUB a=0, b=1 -> 0xFFFFFFFF.
- Shifts: SRA a=0x80000000, b=0x00000024 -> uses shamt 4 -> 0xF8000000. SLL same operands -> 0x00000000. SLT a=0xFFFFFFFF, b=1 -> 1; SLTU same operands -> 0.
- MULH a=0xFFFFFFFE (-2), b=3 -> 0xFFFFFFFF; MUL same operands -> 0xFFFFFFFA. busy=1 for exactly 32 cycles; out_valid at cycle 33 after accept.
- DIV a=-7, b=2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1). DIVU a=7, b=0 -> 0xFFFFFFFF; REMU a=7, b=0 -> 7. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> alu_res stable, in_ready=0, a new in_valid is not accepted. Release out_ready -> IDLE, next op accepted one cycle later.
- Reset mid-DIVU at iteration 10 -> out_valid, busy 0 immediately; after release, ADD 2+3 -> 5 with normal latency.
